// File: rtl/seq_hit_counter_if.sv
// Result/control bundle for seq_hit_counter.
//   en, det_in, cnt_ready         : producer side -> counter
//   cnt_data, cnt_valid, sat,
//   overrun                       : counter -> consumer side
// master: stimulus/consumer side; slave: the counter itself.
interface seq_hit_counter_if #(
    parameter int unsigned CNT_W = 8
) ();
    logic             en;
    logic             det_in;
    logic             cnt_ready;
    logic [CNT_W-1:0] cnt_data;
    logic             cnt_valid;
    logic             sat;
    logic             overrun;

    modport master (
        output en, det_in, cnt_ready,
        input  cnt_data, cnt_valid, sat, overrun
    );

    modport slave (
        input  en, det_in, cnt_ready,
        output cnt_data, cnt_valid, sat, overrun
    );
endinterface

// File: rtl/seq_hit_counter.sv
// Counts det_in hits over fixed windows of WINDOW cycles and presents each
// window's (saturating) count on a valid/ready result port.
//   clk     : clock, rising edge
//   rst     : asynchronous active-high reset
//   bus     : seq_hit_counter_if.slave (en, det_in, cnt_ready in;
//             cnt_data, cnt_valid, sat, overrun out, all registered)
module seq_hit_counter #(
    parameter int unsigned WINDOW = 16,
    parameter int unsigned CNT_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    seq_hit_counter_if.slave   bus
);

    localparam int unsigned      WIN_W    = $clog2(WINDOW);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIN_W-1:0] wcnt_q, wcnt_d;
    logic [CNT_W-1:0] hit_q, hit_d;
    logic             hsat_q, hsat_d;
    logic [CNT_W-1:0] cnt_data_q, cnt_data_d;
    logic             cnt_valid_q, cnt_valid_d;
    logic             sat_q, sat_d;
    logic             overrun_q, overrun_d;

    logic [CNT_W-1:0] hit_nxt;
    logic             hsat_nxt;

    // Next-state, counters and result port
    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        hit_d       = hit_q;
        hsat_d      = hsat_q;
        cnt_data_d  = cnt_data_q;
        cnt_valid_d = cnt_valid_q;
        sat_d       = sat_q;
        overrun_d   = 1'b0;
        hit_nxt     = hit_q;
        hsat_nxt    = hsat_q;

        // Count including this cycle's det_in; a hit at max sets the sticky flag
        if (bus.det_in) begin
            if (hit_q == CNT_MAX) begin
                hsat_nxt = 1'b1;
            end else begin
                hit_nxt = hit_q + CNT_W'(1);
            end
        end

        if (cnt_valid_q && bus.cnt_ready) begin
            cnt_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                wcnt_d = '0;
                hit_d  = '0;
                hsat_d = 1'b0;
                // The entering edge is window cycle 0 (counters are 0 here)
                if (bus.en) begin
                    state_d = COUNT;
                    wcnt_d  = WIN_W'(1);
                    hit_d   = hit_nxt;
                    hsat_d  = hsat_nxt;
                end
            end
            COUNT: begin
                if (!bus.en) begin
                    state_d = IDLE;
                    wcnt_d  = '0;
                    hit_d   = '0;
                    hsat_d  = 1'b0;
                end else if (wcnt_q == WIN_LAST) begin
                    wcnt_d = '0;
                    hit_d  = '0;
                    hsat_d = 1'b0;
                    // Blocked consumer keeps the old result; the new one is lost
                    if (cnt_valid_q && !bus.cnt_ready) begin
                        overrun_d = 1'b1;
                    end else begin
                        cnt_data_d  = hit_nxt;
                        sat_d       = hsat_nxt;
                        cnt_valid_d = 1'b1;
                    end
                end else begin
                    wcnt_d = wcnt_q + WIN_W'(1);
                    hit_d  = hit_nxt;
                    hsat_d = hsat_nxt;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wcnt_q      <= '0;
            hit_q       <= '0;
            hsat_q      <= 1'b0;
            cnt_data_q  <= '0;
            cnt_valid_q <= 1'b0;
            sat_q       <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            hit_q       <= hit_d;
            hsat_q      <= hsat_d;
            cnt_data_q  <= cnt_data_d;
            cnt_valid_q <= cnt_valid_d;
            sat_q       <= sat_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.cnt_data  = cnt_data_q;
    assign bus.cnt_valid = cnt_valid_q;
    assign bus.sat       = sat_q;
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_seq_hit_counter.sv
// Directed bench for seq_hit_counter: an 8-bit-count instance for the main
// scenarios and a 3-bit-count instance for saturation.
module tb_seq_hit_counter;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    seq_hit_counter_if #(.CNT_W(8)) b ();
    seq_hit_counter_if #(.CNT_W(3)) b3 ();

    seq_hit_counter #(.WINDOW(16), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (b.slave)
    );

    seq_hit_counter #(.WINDOW(16), .CNT_W(3)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (b3.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // 16 cycles with en=1, det_in/cnt_ready taken bit i per cycle
    task automatic win(input logic [15:0] pat, input logic [15:0] rdy);
        for (int i = 0; i < 16; i++) begin
            b.en        = 1'b1;
            b.det_in    = pat[i];
            b.cnt_ready = rdy[i];
            tick();
        end
    endtask

    task automatic idle(input int n, input logic det, input logic rdy);
        for (int i = 0; i < n; i++) begin
            b.en        = 1'b0;
            b.det_in    = det;
            b.cnt_ready = rdy;
            tick();
        end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        b.en         = 1'b0;
        b.det_in     = 1'b0;
        b.cnt_ready  = 1'b0;
        b3.en        = 1'b0;
        b3.det_in    = 1'b0;
        b3.cnt_ready = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_valid", 32'(b.cnt_valid), 0);
        check("rst_data", 32'(b.cnt_data), 0);
        check("rst_sat", 32'(b.sat), 0);
        check("rst_overrun", 32'(b.overrun), 0);
        #2;
        rst = 1'b0;

        // Basic window: 5 hits incl. first and last cycle
        idle(1, 1'b1, 1'b1);
        win(16'h8189, 16'hFFFF);
        check("basic_valid", 32'(b.cnt_valid), 1);
        check("basic_data", 32'(b.cnt_data), 5);
        check("basic_sat", 32'(b.sat), 0);
        idle(1, 1'b1, 1'b1);
        check("basic_xfer_valid", 32'(b.cnt_valid), 0);

        // Overrun: 3 then 9 with consumer stalled
        idle(2, 1'b1, 1'b1);
        win(16'h8021, 16'h0000);
        check("ovr_first_valid", 32'(b.cnt_valid), 1);
        check("ovr_first_data", 32'(b.cnt_data), 3);
        check("ovr_first_pulse", 32'(b.overrun), 0);
        win(16'h01FF, 16'h0000);
        check("ovr_pulse", 32'(b.overrun), 1);
        check("ovr_keep_data", 32'(b.cnt_data), 3);
        check("ovr_keep_valid", 32'(b.cnt_valid), 1);
        idle(1, 1'b0, 1'b0);
        check("ovr_pulse_end", 32'(b.overrun), 0);
        check("ovr_hold_data", 32'(b.cnt_data), 3);
        idle(1, 1'b0, 1'b1);
        check("ovr_xfer_valid", 32'(b.cnt_valid), 0);

        // Back-to-back: transfer coincides with next window end
        idle(1, 1'b0, 1'b1);
        win(16'h0F00, 16'h0000);
        check("b2b_first_data", 32'(b.cnt_data), 4);
        check("b2b_first_valid", 32'(b.cnt_valid), 1);
        for (int i = 0; i < 16; i++) begin
            logic [15:0] p;
            p           = 16'hC00F;
            b.en        = 1'b1;
            b.det_in    = p[i];
            b.cnt_ready = (i == 15);
            tick();
            check("b2b_valid_cont", 32'(b.cnt_valid), 1);
            check("b2b_no_overrun", 32'(b.overrun), 0);
        end
        check("b2b_second_data", 32'(b.cnt_data), 6);
        idle(1, 1'b0, 1'b1);
        check("b2b_xfer_valid", 32'(b.cnt_valid), 0);

        // Abort at window cycle 10 with 4 hits, then a full window of 2 hits
        idle(2, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            b.en        = 1'b1;
            b.det_in    = (i < 4);
            b.cnt_ready = 1'b1;
            tick();
        end
        idle(3, 1'b0, 1'b1);
        check("abort_no_result", 32'(b.cnt_valid), 0);
        win(16'h0012, 16'hFFFF);
        check("abort_after_valid", 32'(b.cnt_valid), 1);
        check("abort_after_data", 32'(b.cnt_data), 2);
        idle(1, 1'b0, 1'b1);

        // Async reset at window cycle 7 with a pending result
        win(16'h8189, 16'h0000);
        check("arst_pre_valid", 32'(b.cnt_valid), 1);
        for (int i = 0; i < 7; i++) begin
            b.en        = 1'b1;
            b.det_in    = 1'b1;
            b.cnt_ready = 1'b0;
            tick();
        end
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(b.cnt_valid), 0);
        check("arst_data", 32'(b.cnt_data), 0);
        check("arst_sat", 32'(b.sat), 0);
        check("arst_overrun", 32'(b.overrun), 0);
        #2;
        rst = 1'b0;
        win(16'h8021, 16'hFFFF);
        check("arst_post_valid", 32'(b.cnt_valid), 1);
        check("arst_post_data", 32'(b.cnt_data), 3);
        idle(1, 1'b0, 1'b1);

        // Saturation with a 3-bit count, then a clean window clears sat
        for (int i = 0; i < 16; i++) begin
            b3.en        = 1'b1;
            b3.det_in    = 1'b1;
            b3.cnt_ready = 1'b1;
            tick();
        end
        check("sat_valid", 32'(b3.cnt_valid), 1);
        check("sat_data", 32'(b3.cnt_data), 7);
        check("sat_flag", 32'(b3.sat), 1);
        for (int i = 0; i < 16; i++) begin
            b3.det_in = (i == 0) || (i == 8);
            tick();
        end
        check("unsat_valid", 32'(b3.cnt_valid), 1);
        check("unsat_data", 32'(b3.cnt_data), 2);
        check("unsat_flag", 32'(b3.sat), 0);
        b3.en = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_hit_counter.md
SEQ_HIT_COUNTER -- requirements
Module: seq_hit_counter

Interface
REQ-001 SHALL provide parameter WINDOW, default 16; window length in clock cycles (legal range 2..256).
REQ-002 SHALL provide parameter CNT_W, default 8; width of the hit count in bits (legal range 2..16).
REQ-003 SHALL provide port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL provide port rst  input  1  reset; asynchronous, active-high.
REQ-005 SHALL provide port en  input  1  counting enable.
REQ-006 SHALL provide port det_in  input  1  per-cycle detection flag driven by the upstream sequence detector output.
REQ-007 SHALL provide port cnt_data  output  CNT_W  hit count of the last completed window.
REQ-008 SHALL provide port cnt_valid  output  1  cnt_data holds an untransferred result.
REQ-009 SHALL provide port cnt_ready  input  1  consumer accepts cnt_data.
REQ-010 SHALL provide port sat  output  1  the result in cnt_data saturated.
REQ-011 SHALL provide port overrun  output  1  one-cycle pulse: a completed window result was dropped.

Function
REQ-012 SHALL implement a two-state FSM: IDLE and COUNT.
REQ-013 IDLE -> COUNT on the first edge with en=1; window cycle counter and hit counter SHALL be 0 on entry, and det_in SHALL be sampled starting that edge.
REQ-014 In COUNT, each edge with det_in=1 SHALL increment the hit counter by 1, saturating at 2^CNT_W-1.
REQ-015 The window cycle counter SHALL advance 0..WINDOW-1 once per COUNT cycle, then wrap to 0.
REQ-016 Window end is the COUNT cycle where the window counter equals WINDOW-1.
REQ-017 At window end, the final count, including that cycle's det_in, SHALL load into cnt_data.
REQ-018 After a window-end load, cnt_valid SHALL be 1 on the following cycle (latency 1 from the last sampled bit).
REQ-019 At window end, the hit counter SHALL clear, and the next window SHALL start on the next edge with no gap cycle.
REQ-020 sat SHALL load with cnt_data and be 1 if the count saturated during that window.
REQ-021 A transfer SHALL occur on an edge where cnt_valid=1 and cnt_ready=1.
REQ-022 After a transfer, cnt_valid SHALL drop unless a new result loads on the same edge.
REQ-023 While cnt_valid=1 and cnt_ready=0, cnt_data, sat and cnt_valid SHALL hold stable.
REQ-024 Window end with cnt_valid=1 and cnt_ready=0: the new result SHALL be dropped, the old result kept, and overrun SHALL pulse high for exactly one cycle.
REQ-025 Window end coinciding with a transfer: the new result SHALL load, cnt_valid SHALL stay 1, and overrun SHALL stay 0.
REQ-026 en=0 in COUNT SHALL discard the partial window: the FSM goes to IDLE and both counters clear on that edge.
REQ-027 en=0 SHALL NOT affect cnt_data, cnt_valid or sat; a pending result remains transferable.
REQ-028 det_in SHALL be ignored in IDLE.
REQ-029 cnt_ready SHALL be ignored when cnt_valid=0.

Reset
REQ-030 rst=1 SHALL immediately, without clock, force: FSM to IDLE, both counters to 0, cnt_data=0, cnt_valid=0, sat=0, overrun=0.
REQ-031 Reset mid-window or with a pending result SHALL discard all in-flight and pending data.
REQ-032 Operation SHALL resume on the first rising clk edge after rst falls, subject to en.

Verification
REQ-033 WINDOW=16, CNT_W=8, en=1, cnt_ready=1, det_in high on 5 of the first 16 cycles -> cnt_valid=1 for one cycle with cnt_data=5, sat=0.
REQ-034 CNT_W=3, WINDOW=16, det_in=1 for all 16 cycles -> cnt_data=7, sat=1.
REQ-035 cnt_ready=0 across two window ends with counts 3 then 9 -> cnt_data holds 3, one overrun pulse at the second window end; raising cnt_ready then transfers 3.
REQ-036 cnt_ready=1 on exactly the edge of the next window end -> back-to-back results 4 then 6, cnt_valid continuously 1, overrun never 1.
REQ-037 en dropped at window cycle 10 with 4 hits, re-raised later with 2 hits over a full window -> result 2, no result emitted for the aborted window.
REQ-038 rst pulsed asynchronously (between edges) at window cycle 7 with cnt_valid=1 -> all outputs 0 immediately; first result after release counts only post-reset hits.
